// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame timing,
// common to the receive and transmit paths.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 87;
  localparam int DATA_BITS_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte handshake: one-entry valid/ready buffer from receiver to consumer.
interface uart_rx_if #(
  parameter int DATA_BITS = uart_pkg::DATA_BITS_DEF
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous pad inputs.
module sync_2ff #(
  parameter int   WIDTH   = 1,
  parameter logic RST_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= {WIDTH{RST_VAL}};
      r_sync <= {WIDTH{RST_VAL}};
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a one-entry valid/ready
// output buffer, with framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  uart_rx_if.master  rx_bus,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS) + 1;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic w_rx_s;
  logic w_tick;
  logic w_stop_ok;
  logic w_stop_bad;
  logic w_can_load;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx_i),
    .o_q   (w_rx_s)
  );

  assign w_tick     = (r_cnt == '0);
  assign w_stop_ok  = (r_state == STOP) && w_tick && w_rx_s;
  assign w_stop_bad = (r_state == STOP) && w_tick && !w_rx_s;
  assign w_can_load = !r_valid || rx_bus.rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state <= START;
            r_cnt   <= HALF_LOAD;
          end
        end
        START: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!w_rx_s) begin
            r_state <= DATA;
            r_cnt   <= FULL_LOAD;
            r_idx   <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
        DATA: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            // Shifting in at the MSB leaves bit 0 holding the first data bit.
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_cnt   <= FULL_LOAD;
            r_idx   <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) r_state <= STOP;
          end
        end
        STOP: begin
          if (!w_tick)     r_cnt   <= r_cnt - 1'b1;
          else if (w_rx_s) r_state <= IDLE;
          else             r_state <= BREAK;
        end
        BREAK: begin
          if (w_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Delivery and accept in the same cycle reload the buffer, so valid stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_stop_ok && w_can_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_bus.rx_ready) begin
        r_valid <= 1'b0;
      end
      r_overrun   <= w_stop_ok && !w_can_load;
      r_frame_err <= w_stop_bad;
    end
  end

  assign rx_bus.rx_data  = r_data;
  assign rx_bus.rx_valid = r_valid;
  assign frame_err       = r_frame_err;
  assign overrun         = r_overrun;
  assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks per bit.
module tb_uart_rx;

  logic clk;
  logic rst_n;
  logic rx_i;
  logic frame_err;
  logic overrun;
  logic busy;

  int checks = 0;
  int errors = 0;

  int acc_cnt = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;
  logic [7:0] last_data = '0;

  int acc0, fe0, ov0;
  logic snap_valid, snap_fe, snap_ov, snap_busy;
  logic [7:0] snap_data;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.CLKS_PER_BIT(8), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_i      (rx_i),
    .rx_bus    (bus),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_ready) begin
      acc_cnt++;
      last_data = bus.rx_data;
    end
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    acc0 = acc_cnt;
    fe0  = fe_cnt;
    ov0  = ov_cnt;
  endtask

  // Drives one frame; bit n occupies cycles 8n..8n+7 after the first edge.
  // rdy_cyc raises rx_ready for one cycle, rst_cyc asserts reset and snapshots outputs.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int rdy_cyc, input int rst_cyc);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      rx_i = f[c / 8];
      if (c == rdy_cyc) bus.rx_ready = 1'b1;
      else if (rdy_cyc >= 0 && c == rdy_cyc + 1) bus.rx_ready = 1'b0;
      if (c == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        snap_valid = bus.rx_valid;
        snap_data  = bus.rx_data;
        snap_fe    = frame_err;
        snap_ov    = overrun;
        snap_busy  = busy;
      end
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_i  = 1'b1;
    bus.rx_ready = 1'b0;
    settle(3);
    chk("rst_valid", 32'(bus.rx_valid), 32'h0);
    chk("rst_data",  32'(bus.rx_data),  32'h0);
    chk("rst_fe",    32'(frame_err),    32'h0);
    chk("rst_ov",    32'(overrun),      32'h0);
    chk("rst_busy",  32'(busy),         32'h0);
    rst_n = 1'b1;
    bus.rx_ready = 1'b1;
    settle(4);
    chk("idle_busy", 32'(busy), 32'h0);

    // 1: single frame
    mark();
    send_frame(8'hA5, 1'b1, -1, -1);
    settle(3);
    chk("t1_acc",   32'(acc_cnt - acc0), 32'd1);
    chk("t1_data",  32'(last_data),      32'hA5);
    chk("t1_fe",    32'(fe_cnt - fe0),   32'd0);
    chk("t1_ov",    32'(ov_cnt - ov0),   32'd0);
    chk("t1_busy",  32'(busy),           32'h0);
    chk("t1_valid", 32'(bus.rx_valid),   32'h0);

    // 2: start glitch, then a good frame
    mark();
    @(posedge clk); #1 rx_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_i = 1'b1;
    settle(20);
    chk("t2_acc",  32'(acc_cnt - acc0), 32'd0);
    chk("t2_fe",   32'(fe_cnt - fe0),   32'd0);
    chk("t2_ov",   32'(ov_cnt - ov0),   32'd0);
    chk("t2_busy", 32'(busy),           32'h0);
    send_frame(8'h5A, 1'b1, -1, -1);
    settle(3);
    chk("t2_acc2", 32'(acc_cnt - acc0), 32'd1);
    chk("t2_data", 32'(last_data),      32'h5A);

    // 3: framing error with held-low line
    mark();
    send_frame(8'h3C, 1'b0, -1, -1);
    settle(20);
    chk("t3_break_busy", 32'(busy), 32'h1);
    rx_i = 1'b1;
    settle(6);
    chk("t3_fe",   32'(fe_cnt - fe0),   32'd1);
    chk("t3_acc",  32'(acc_cnt - acc0), 32'd0);
    chk("t3_ov",   32'(ov_cnt - ov0),   32'd0);
    chk("t3_busy", 32'(busy),           32'h0);
    send_frame(8'h0F, 1'b1, -1, -1);
    settle(3);
    chk("t3_acc2", 32'(acc_cnt - acc0), 32'd1);
    chk("t3_data", 32'(last_data),      32'h0F);
    chk("t3_fe2",  32'(fe_cnt - fe0),   32'd1);

    // 4: overrun
    mark();
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1);
    settle(3);
    chk("t4_valid", 32'(bus.rx_valid),   32'h1);
    chk("t4_data",  32'(bus.rx_data),    32'h11);
    chk("t4_ov",    32'(ov_cnt - ov0),   32'd1);
    chk("t4_fe",    32'(fe_cnt - fe0),   32'd0);
    chk("t4_acc",   32'(acc_cnt - acc0), 32'd0);
    @(posedge clk); #1 bus.rx_ready = 1'b1;
    @(posedge clk); #1 bus.rx_ready = 1'b0;
    settle(2);
    chk("t4_valid2", 32'(bus.rx_valid),   32'h0);
    chk("t4_acc2",   32'(acc_cnt - acc0), 32'd1);
    chk("t4_accd",   32'(last_data),      32'h11);
    chk("t4_hold",   32'(bus.rx_data),    32'h11);

    // 5: accept in the same cycle as the next delivery
    mark();
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, 78, -1);
    settle(3);
    chk("t5_valid", 32'(bus.rx_valid),   32'h1);
    chk("t5_data",  32'(bus.rx_data),    32'h22);
    chk("t5_ov",    32'(ov_cnt - ov0),   32'd0);
    chk("t5_acc",   32'(acc_cnt - acc0), 32'd1);
    chk("t5_accd",  32'(last_data),      32'h11);

    // 6: reset during data bit 4, then a clean frame
    mark();
    send_frame(8'h77, 1'b1, -1, 44);
    chk("t6_rst_valid", 32'(snap_valid), 32'h0);
    chk("t6_rst_data",  32'(snap_data),  32'h0);
    chk("t6_rst_fe",    32'(snap_fe),    32'h0);
    chk("t6_rst_ov",    32'(snap_ov),    32'h0);
    chk("t6_rst_busy",  32'(snap_busy),  32'h0);
    rst_n = 1'b1;
    bus.rx_ready = 1'b1;
    settle(4);
    chk("t6_idle_valid", 32'(bus.rx_valid), 32'h0);
    chk("t6_idle_busy",  32'(busy),         32'h0);
    send_frame(8'h99, 1'b1, -1, -1);
    settle(3);
    chk("t6_acc",  32'(acc_cnt - acc0), 32'd1);
    chk("t6_data", 32'(last_data),      32'h99);
    chk("t6_fe",   32'(fe_cnt - fe0),   32'd0);
    chk("t6_ov",   32'(ov_cnt - ov0),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the counterpart to the chip's UART transmit path (uo_out / uart_tx_pin), taking serial data in on a ui_in bit.
- Recovers 8N1 frames by mid-bit sampling and presents each byte on a one-entry valid/ready output buffer.
- Flags framing and overrun errors.
- Sits between a top-level pad input and the design's command/loopback logic.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per bit (10 MHz / 115200); must be >= 4.
- DATA_BITS, 8, data bits per frame, LSB first; no parity.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_i  input  1  raw serial line, idle high, asynchronous to clk
- rx_data  output  DATA_BITS  received byte; stable while rx_valid=1
- rx_valid  output  1  byte available
- rx_ready  input  1  consumer accepts when rx_valid && rx_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- overrun  output  1  one-cycle pulse: byte completed while buffer full, new byte dropped
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). While rst_n=0:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - FSM=IDLE, synchronizer FFs=1.
- Reset mid-frame aborts the frame; no partial byte is ever delivered.
- Input: rx_i passes through a 2-FF synchronizer to give rx_s. All decisions use rx_s, which adds 2 cycles of latency.
- Bit counter width: $clog2(CLKS_PER_BIT). Bit index width: $clog2(DATA_BITS)+1.
- IDLE:
  - rx_s=0 -> START; counter loaded with CLKS_PER_BIT/2 - 1 (integer division).
- START:
  - Count down to 0, then sample rx_s.
  - Sample 0 -> DATA; counter=CLKS_PER_BIT-1; index=0.
  - Sample 1 -> glitch: back to IDLE, no flags raised.
- DATA:
  - Count to 0, sample rx_s into shift[index] (LSB first), reload counter.
  - After DATA_BITS samples -> STOP.
- STOP:
  - Count to 0, then sample rx_s.
  - Sample 1 -> deliver the byte, go to IDLE. Receiver returns to IDLE at mid-stop, so a start bit arriving half a bit later is caught.
  - Sample 0 -> frame_err pulses 1 cycle, byte discarded, go to BREAK.
- BREAK:
  - Wait for rx_s=1, then go to IDLE. Covers a held-low line or break condition; no repeated frame_err.
- Deliver (cycle after the stop sample):
  - If rx_valid=0, or rx_valid && rx_ready in that same cycle: rx_data <= shift, rx_valid <= 1.
  - Otherwise: overrun pulses 1 cycle; rx_data and rx_valid are unchanged (old byte kept).
- Accept: rx_valid && rx_ready with no simultaneous delivery -> rx_valid <= 0 next cycle. rx_data holds its value.
- rx_valid never drops without an accept. rx_ready is ignored while rx_valid=0.
- End-to-end latency: rx_valid rises 2 (sync) + 1 cycles after the mid-stop sampling point.
- frame_err and overrun are mutually exclusive; both are registered.

Decomposition:
- Shared package uart_pkg:
  - State enum rx_state_t {IDLE, START, DATA, STOP, BREAK}.
  - Default constants CLKS_PER_BIT_DEF=87 and DATA_BITS_DEF=8, shared with the transmit side.
- One sub-module: sync_2ff. Generic 2-flop synchronizer with reset value parameter RST_VAL=1; reused for the other pad inputs.
- Everything else stays in uart_rx: the FSM, the counters and the output buffer.

Test Plan:
All scenarios use CLKS_PER_BIT=8, DATA_BITS=8, rx_ready=1 unless stated.
1. Single frame: drive frame 0xA5 (0,1,0,1,0,0,1,0,1,1) -> rx_data=0xA5 with one rx_valid pulse; frame_err=0, overrun=0; busy low after the stop sample.
2. Start glitch: rx_i low for 3 cycles, then high -> back to IDLE; rx_valid, frame_err and overrun all stay 0. A following frame 0x5A is then received correctly.
3. Framing error: frame 0x3C with stop bit=0, held low 20 cycles, then high -> exactly one frame_err pulse, no rx_valid. Next frame 0x0F is received correctly.
4. Overrun: rx_ready=0, send back-to-back frames 0x11 then 0x22 -> rx_data=0x11 held, one overrun pulse at the 0x22 stop. Raise rx_ready -> 0x11 accepted, then rx_valid=0.
5. Simultaneous accept and delivery: hold rx_valid with 0x11; assert rx_ready exactly in 0x22's delivery cycle -> rx_data=0x22, rx_valid stays 1, no overrun.
6. Reset mid-frame: assert rst_n=0 during data bit 4 of 0x77 -> all outputs 0 immediately. Release and send 0x99 -> only 0x99 is delivered.
